uart_tx_fifo: RTL and testbench
===============================

UART_TX_FIFO -- requirements
Module: uart_tx_fifo

Interface
REQ-001 Parameter CLK_DIV, default 868, SHALL set clock cycles per UART bit (100 MHz / 115200 baud); legal range 2..65535.
REQ-002 clk  input  1  system clock; all state SHALL update on its rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 uart_we  input  1  write strobe from the bus decoder; one byte is offered per cycle while high.
REQ-005 wdata  input  8  byte to enqueue, the low byte of the CPU peripheral data word.
REQ-006 clr_ovf  input  1  clears the sticky overflow flag when high.
REQ-007 txd  output  1  serial line, idle high, 8N1 framing.
REQ-008 busy  output  1  high while a frame is on the line.
REQ-009 full  output  1  FIFO holds 8 bytes.
REQ-010 empty  output  1  FIFO holds 0 bytes.
REQ-011 count  output  4  FIFO occupancy, 0..8.
REQ-012 status  output  32  CPU readback word {24'h0, ovf, busy, full, empty, count[3:0]}.

Function
REQ-013 FIFO SHALL be 8 entries x 8 bits: circular buffer, 3-bit read and write pointers that wrap 7->0, and a 4-bit occupancy counter.
REQ-014 Write accept SHALL be uart_we & ~full, where full is the registered value at the start of the cycle.
REQ-015 An accepted write SHALL store wdata at the write pointer and advance the pointer.
REQ-016 uart_we while full SHALL drop the byte, leave pointers and count unchanged, and set ovf.
REQ-017 ovf SHALL stay set until clr_ovf is high. If set and clear occur in the same cycle, set wins.
REQ-018 On a simultaneous accepted write and pop, count SHALL be unchanged and both pointers SHALL advance.
REQ-019 A write while full SHALL be dropped even if a pop occurs in the same cycle.
REQ-020 full SHALL be (count==8), empty SHALL be (count==0), and count SHALL reflect accepted writes and pops from the cycle after they occur.
REQ-021 TX FSM states: IDLE, START, DATA, STOP; one baud counter (16-bit) and one bit index (3-bit).
REQ-022 IDLE: txd=1. If count!=0 at the edge, the FSM SHALL pop the head byte into an 8-bit shifter, clear the baud counter, and go to START.
REQ-023 START: txd=0 for CLK_DIV cycles, then go to DATA with bit index 0.
REQ-024 DATA: txd=shifter[0] for CLK_DIV cycles per bit, then shift right; bits go LSB first. After bit index 7 completes, go to STOP.
REQ-025 STOP: txd=1 for CLK_DIV cycles, then go to IDLE.
REQ-026 A frame SHALL last exactly 10*CLK_DIV cycles, and at least one IDLE cycle SHALL separate consecutive frames.
REQ-027 txd SHALL be driven from a register (glitch-free).
REQ-028 busy SHALL be (state != IDLE).
REQ-029 Latency: a write accepted at edge k into an empty FIFO with the FSM in IDLE gives count=1 after edge k. The pop occurs at edge k+1, and txd falls after edge k+1.
REQ-030 FIFO writes during a frame SHALL NOT disturb the frame in progress.
REQ-031 The baud counter SHALL count 0..CLK_DIV-1 and wrap to 0 on each bit boundary, with no drift across the frame.

Reset
REQ-032 With rst high at an edge, the block SHALL set:
- pointers=0, count=0, ovf=0;
- state=IDLE, baud counter=0, bit index=0, shifter=0;
- txd=1, busy=0, full=0, empty=1, status=32'h0000_0010.
REQ-033 Reset SHALL take priority over uart_we and clr_ovf in the same cycle.
REQ-034 Reset mid-frame SHALL abort the frame: txd=1 from the next cycle, and all queued bytes are discarded.
REQ-035 Outputs SHALL be stable and defined in the cycle following reset deassertion.

Verification (CLK_DIV=4)
REQ-036 Single write of 8'h55 from idle -> txd levels 0,1,0,1,0,1,0,1,0,1, each held 4 cycles; frame length 40 cycles; busy high for exactly 40 cycles.
REQ-037 Nine back-to-back writes of 8'h01..8'h09 while idle -> the first is popped at once. Expected result:
- the FIFO peaks at count=8 with full=1, and no overflow occurs;
- all nine bytes are transmitted in order, each frame separated by 1 idle cycle.
REQ-038 Fill the FIFO while a frame is in progress, then write 8'hAA -> byte dropped, ovf=1, status[7]=1. Then pulse clr_ovf -> ovf=0 from the next cycle.
REQ-039 With count=8, assert uart_we on the exact pop cycle -> write dropped, count=7, ovf=1.
REQ-040 Assert rst during the DATA state of byte 8'hF0 with 3 bytes queued -> the next cycle shows txd=1, busy=0, count=0, status=32'h0000_0010. A write after reset transmits normally.
REQ-041 clr_ovf and an overflowing write in the same cycle -> ovf=1 after that edge.

Source files
------------

// File: rtl/uart_tx_fifo.sv
// rtl/uart_tx_fifo.sv - 8-entry byte FIFO feeding an 8N1 UART transmitter
// Bytes are popped only from IDLE, so at least one idle cycle separates frames.
module uart_tx_fifo #(
  parameter int CLK_DIV = 868
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        uart_we,
  input  logic [7:0]  wdata,
  input  logic        clr_ovf,
  output logic        txd,
  output logic        busy,
  output logic        full,
  output logic        empty,
  output logic [3:0]  count,
  output logic [31:0] status
);

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

  localparam logic [15:0] BAUD_LAST = 16'(CLK_DIV - 1);

  logic [7:0]  mem_q [8];
  logic [2:0]  wptr_q, wptr_d, rptr_q, rptr_d;
  logic [3:0]  count_q, count_d;
  logic        ovf_q, ovf_d;
  state_t      state_q, state_d;
  logic [15:0] baud_q, baud_d;
  logic [2:0]  bit_q, bit_d;
  logic [7:0]  shift_q, shift_d;
  logic        txd_q, txd_d;
  logic        we_acc, pop, baud_end;

  assign full   = (count_q == 4'd8);
  assign empty  = (count_q == 4'd0);
  assign count  = count_q;
  assign busy   = (state_q != S_IDLE);
  assign txd    = txd_q;
  assign status = {24'h0, ovf_q, busy, full, empty, count_q};

  always_comb begin
    we_acc   = uart_we & ~full;
    pop      = (state_q == S_IDLE) && (count_q != 4'd0);
    baud_end = (baud_q == BAUD_LAST);

    wptr_d = we_acc ? wptr_q + 3'd1 : wptr_q;
    rptr_d = pop ? rptr_q + 3'd1 : rptr_q;
    case ({we_acc, pop})
      2'b10:   count_d = count_q + 4'd1;
      2'b01:   count_d = count_q - 4'd1;
      default: count_d = count_q;
    endcase

    // A dropped write outranks a same-cycle clear so no overflow is lost.
    ovf_d = ovf_q;
    if (clr_ovf) ovf_d = 1'b0;
    if (uart_we && full) ovf_d = 1'b1;

    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    case (state_q)
      S_IDLE: begin
        if (pop) begin
          shift_d = mem_q[rptr_q];
          baud_d  = 16'd0;
          state_d = S_START;
        end
      end
      S_START: begin
        if (baud_end) begin
          baud_d  = 16'd0;
          bit_d   = 3'd0;
          state_d = S_DATA;
        end else begin
          baud_d = baud_q + 16'd1;
        end
      end
      S_DATA: begin
        if (baud_end) begin
          baud_d  = 16'd0;
          shift_d = {1'b0, shift_q[7:1]};
          if (bit_q == 3'd7) state_d = S_STOP;
          else bit_d = bit_q + 3'd1;
        end else begin
          baud_d = baud_q + 16'd1;
        end
      end
      default: begin
        if (baud_end) begin
          baud_d  = 16'd0;
          state_d = S_IDLE;
        end else begin
          baud_d = baud_q + 16'd1;
        end
      end
    endcase

    // Line level is precomputed from the next state so txd comes straight off a flop.
    case (state_d)
      S_START: txd_d = 1'b0;
      S_DATA:  txd_d = shift_d[0];
      default: txd_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (we_acc) mem_q[wptr_q] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q  <= 3'd0;
      rptr_q  <= 3'd0;
      count_q <= 4'd0;
      ovf_q   <= 1'b0;
      state_q <= S_IDLE;
      baud_q  <= 16'd0;
      bit_q   <= 3'd0;
      shift_q <= 8'd0;
      txd_q   <= 1'b1;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      txd_q   <= txd_d;
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb/tb_uart_tx_fifo.sv - directed self-checking bench for uart_tx_fifo (CLK_DIV=4)
module tb_uart_tx_fifo;

  logic        clk, rst, uart_we, clr_ovf;
  logic [7:0]  wdata;
  logic        txd, busy, full, empty;
  logic [3:0]  count;
  logic [31:0] status;

  int checks = 0;
  int errors = 0;

  logic [7:0] rx_q[$];
  bit         rx_ok_q[$];
  int         rx_gap_q[$];

  uart_tx_fifo #(.CLK_DIV(4)) dut (
    .clk(clk), .rst(rst), .uart_we(uart_we), .wdata(wdata), .clr_ovf(clr_ovf),
    .txd(txd), .busy(busy), .full(full), .empty(empty), .count(count), .status(status)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    if (obs !== exp_v) begin
      errors++;
      $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp_v);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [7:0] b);
    uart_we = 1'b1;
    wdata   = b;
    tick;
    uart_we = 1'b0;
  endtask

  task automatic clr_q;
    rx_q.delete();
    rx_ok_q.delete();
    rx_gap_q.delete();
  endtask

  task automatic wait_rx(input int n, input int limit);
    int c = 0;
    while (rx_q.size() < n && c < limit) begin
      tick;
      c++;
    end
    chk("rx_frames", rx_q.size(), n);
  endtask

  // Line receiver: captures 40 samples per frame and requires each bit to hold 4 cycles.
  initial begin : mon
    int idx, idle_run;
    bit act, ok;
    logic [39:0] smp;
    logic [7:0] d;
    act = 0; idle_run = 0; idx = 0; smp = '0;
    forever begin
      @(posedge clk);
      #1;
      if (rst) begin
        act = 0;
        idle_run = 0;
      end else if (!act) begin
        if (txd == 1'b0) begin
          act = 1; idx = 1; smp = '0;
          rx_gap_q.push_back(idle_run);
          idle_run = 0;
        end else begin
          idle_run++;
        end
      end else begin
        smp[idx] = txd;
        idx++;
        if (idx == 40) begin
          act = 0;
          ok = (smp[0] == 1'b0) && (smp[36] == 1'b1);
          for (int j = 0; j < 10; j++)
            for (int c = 0; c < 4; c++)
              if (smp[4*j+c] !== smp[4*j]) ok = 0;
          for (int j = 0; j < 8; j++) d[j] = smp[4*(j+1)];
          rx_q.push_back(d);
          rx_ok_q.push_back(ok);
        end
      end
    end
  end

  initial begin
    int bcnt, c;
    logic [3:0] maxcnt;
    logic ovf_seen;
    rst = 1'b1; uart_we = 1'b0; wdata = 8'h00; clr_ovf = 1'b0;

    // reset state
    tick; tick;
    chk("rst_status", status, 32'h10);
    chk("rst_txd", {31'b0, txd}, 32'h1);
    chk("rst_busy", {31'b0, busy}, 32'h0);
    rst = 1'b0;
    tick;
    chk("post_rst_status", status, 32'h10);
    chk("post_rst_txd", {31'b0, txd}, 32'h1);

    // single byte 0x55, latency and frame length
    clr_q;
    wr(8'h55);
    chk("lat_count", {28'b0, count}, 32'h1);
    chk("lat_txd_hi", {31'b0, txd}, 32'h1);
    tick;
    chk("lat_txd_lo", {31'b0, txd}, 32'h0);
    chk("lat_busy", {31'b0, busy}, 32'h1);
    chk("lat_popped", {28'b0, count}, 32'h0);
    bcnt = 1;
    for (int i = 0; i < 60; i++) begin
      tick;
      if (!busy) break;
      bcnt++;
    end
    chk("busy_len", bcnt, 40);
    chk("idle_txd", {31'b0, txd}, 32'h1);
    wait_rx(1, 10);
    if (rx_q.size() >= 1) begin
      chk("b55_data", {24'b0, rx_q[0]}, 32'h55);
      chk("b55_ok", {31'b0, rx_ok_q[0]}, 32'h1);
    end
    repeat (5) tick;

    // nine back-to-back writes
    clr_q;
    maxcnt = 0; ovf_seen = 0;
    for (int i = 1; i <= 9; i++) begin
      uart_we = 1'b1;
      wdata   = 8'(i);
      tick;
      if (count > maxcnt) maxcnt = count;
      ovf_seen |= status[7];
    end
    uart_we = 1'b0;
    chk("b2b_peak", {28'b0, maxcnt}, 32'h8);
    chk("b2b_full", {31'b0, full}, 32'h1);
    chk("b2b_no_ovf", {31'b0, ovf_seen}, 32'h0);
    wait_rx(9, 9 * 45 + 50);
    for (int i = 0; i < rx_q.size(); i++) begin
      chk($sformatf("b2b_data%0d", i), {24'b0, rx_q[i]}, 32'(i + 1));
      chk($sformatf("b2b_ok%0d", i), {31'b0, rx_ok_q[i]}, 32'h1);
      if (i > 0) chk($sformatf("b2b_gap%0d", i), rx_gap_q[i], 1);
    end
    repeat (5) tick;

    // overflow while a frame runs, clear, set-vs-clear, write on pop cycle
    clr_q;
    wr(8'h11);
    tick;
    for (int i = 0; i < 8; i++) wr(8'h21 + 8'(i));
    chk("ovf_fill_status", status, 32'h68);
    wr(8'hAA);
    chk("ovf_set_status", status, 32'hE8);
    clr_ovf = 1'b1; tick; clr_ovf = 1'b0;
    chk("ovf_clr_status", status, 32'h68);
    uart_we = 1'b1; wdata = 8'hCC; clr_ovf = 1'b1;
    tick;
    uart_we = 1'b0; clr_ovf = 1'b0;
    chk("ovf_set_wins", status, 32'hE8);
    clr_ovf = 1'b1; tick; clr_ovf = 1'b0;
    c = 0;
    while (busy && c < 100) begin
      tick;
      c++;
    end
    chk("pop_wait_idle", {31'b0, busy}, 32'h0);
    chk("pop_wait_count", {28'b0, count}, 32'h8);
    wr(8'hBB);
    chk("pop_cycle_status", status, 32'hC7);
    clr_ovf = 1'b1; tick; clr_ovf = 1'b0;
    wait_rx(9, 9 * 45 + 50);
    for (int i = 0; i < rx_q.size(); i++)
      chk($sformatf("ovf_data%0d", i), {24'b0, rx_q[i]},
          (i == 0) ? 32'h11 : 32'h20 + 32'(i));
    repeat (5) tick;

    // reset during DATA of 0xF0 with three bytes queued
    clr_q;
    wr(8'hF0);
    wr(8'h31); wr(8'h32); wr(8'h33);
    repeat (6) tick;
    chk("pre_rst_busy", {31'b0, busy}, 32'h1);
    chk("pre_rst_count", {28'b0, count}, 32'h3);
    chk("pre_rst_txd", {31'b0, txd}, 32'h0);
    rst = 1'b1;
    tick;
    chk("abort_txd", {31'b0, txd}, 32'h1);
    chk("abort_busy", {31'b0, busy}, 32'h0);
    chk("abort_count", {28'b0, count}, 32'h0);
    chk("abort_status", status, 32'h10);
    rst = 1'b0;
    tick;
    clr_q;
    wr(8'h5A);
    wait_rx(1, 100);
    if (rx_q.size() >= 1) chk("after_rst_data", {24'b0, rx_q[0]}, 32'h5A);
    repeat (60) tick;
    chk("after_rst_frames", rx_q.size(), 1);
    chk("after_rst_empty", status, 32'h10);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
